rom_prog_ctrl: RTL and testbench

Program-memory controller directly downstream of the UART download receiver. It consumes the receiver's erase pulse and 32-bit word-write pulses and commits them into the instruction ROM array. Erase is a hardware sweep to zero; writes arriving during the sweep are buffered. The block also serves the core's instruction-fetch read port and holds the CPU in reset while a download is in progress.

---
 rtl/rom_prog_ctrl_pkg.sv | 12 +
 rtl/rom_prog_ctrl_sync_fifo.sv | 61 ++++++
 rtl/rom_prog_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rom_prog_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_prog_ctrl_pkg.sv
// Shared constants and state encoding for the program-memory controller.
// Defaults match the production ROM: 4K words, 4-entry write buffer, 0.2 s hold at 50 MHz.
package rom_prog_ctrl_pkg;
    localparam int ROM_ADDR_W       = 12;
    localparam int ROM_FIFO_DEPTH   = 4;
    localparam int ROM_HOLD_TIMEOUT = 10_000_000;

    typedef enum logic {
        ROM_IDLE  = 1'b0,
        ROM_ERASE = 1'b1
    } rom_state_e;
endpackage

// File: rtl/rom_prog_ctrl_sync_fifo.sv
// Generic synchronous FIFO with flush; head is visible combinationally (0-cycle pop latency).
// No internal backpressure: caller pushes only when !full_o or popping; flush then push leaves one entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_slot;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            wr_ptr_d = wr_ptr_d + 1'b1;
        end
    end

    // A push during flush lands in slot 0, where the reset pointers will find it.
    assign wr_slot = flush_i ? '0 : wr_ptr_q[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_slot] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
endmodule

// File: rtl/rom_prog_ctrl.sv
// Instruction ROM behind the download receiver: erase sweep, buffered word writes, fetch port, CPU hold.
// Write-to-memory 2 cycles from an idle start, fetch 1 cycle; writes beyond the buffer are dropped (sticky overflow).
module rom_prog_ctrl
    import rom_prog_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int FIFO_DEPTH   = ROM_FIFO_DEPTH,
    parameter int HOLD_TIMEOUT = ROM_HOLD_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              erase_en_i,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [31:0]       rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic              busy_o,
    output logic              cpu_hold_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   wr_count_o
);
    localparam int              IDLE_W  = $clog2(HOLD_TIMEOUT + 2);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       dat;
    } wr_ent_t;

    rom_state_e        state_q;
    logic [ADDR_W-1:0] sweep_q;
    logic              busy_q;
    logic [31:0]       mem_q [2**ADDR_W];
    logic [31:0]       rd_data_q;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              hold_q, hold_d;

    logic              in_range, push_req, push, pop, fifo_full, fifo_empty;
    wr_ent_t           push_ent, pop_ent;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [31:0]       mem_wdat;
    logic              addr_unused;

    assign in_range = (wr_addr_i[31:ADDR_W+2] == '0);
    assign push_req = wr_en_i && in_range;
    assign pop      = (state_q == ROM_IDLE) && !fifo_empty && !erase_en_i;
    assign push     = push_req && (erase_en_i || !fifo_full || pop);
    assign push_ent = '{idx: wr_addr_i[ADDR_W+1:2], dat: wr_data_i};
    assign addr_unused = ^{wr_addr_i[1:0], rd_addr_i[31:ADDR_W+2], rd_addr_i[1:0]};

    sync_fifo #(
        .WIDTH (ADDR_W + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (erase_en_i),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .pop_dat_o  (pop_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Restarting erase wins over the sweep end in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROM_IDLE;
            sweep_q <= '0;
            busy_q  <= 1'b0;
        end else if (erase_en_i) begin
            state_q <= ROM_ERASE;
            sweep_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ROM_IDLE: begin
                    busy_q <= 1'b0;
                end
                ROM_ERASE: begin
                    if (sweep_q == '1) begin
                        state_q <= ROM_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = pop_ent.idx;
        mem_wdat = pop_ent.dat;
        if (state_q == ROM_ERASE) begin
            mem_we   = 1'b1;
            mem_widx = sweep_q;
            mem_wdat = '0;
        end else if (pop) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdat;
        end
    end

    always_comb begin
        overflow_d = overflow_q | (push_req && !push);
        wr_count_d = wr_count_q;
        if (pop && wr_count_q != CNT_MAX) begin
            wr_count_d = wr_count_q + 1'b1;
        end
        if (erase_en_i) begin
            overflow_d = 1'b0;
            wr_count_d = '0;
        end

        idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
        if (erase_en_i || wr_en_i) begin
            idle_d = '0;
        end

        hold_d = hold_q;
        if (erase_en_i) begin
            hold_d = 1'b1;
        end else if (state_q == ROM_IDLE && fifo_empty && idle_q >= IDLE_W'(HOLD_TIMEOUT)) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
            wr_count_q <= '0;
            idle_q     <= '0;
            hold_q     <= 1'b0;
        end else begin
            rd_data_q  <= mem_q[rd_addr_i[ADDR_W+1:2]];
            overflow_q <= overflow_d;
            wr_count_q <= wr_count_d;
            idle_q     <= idle_d;
            hold_q     <= hold_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign busy_o     = busy_q;
    assign cpu_hold_o = hold_q;
    assign overflow_o = overflow_q;
    assign wr_count_o = wr_count_q;
endmodule

// File: tb/tb_rom_prog_ctrl.sv
// Bench for rom_prog_ctrl: queue/array reference model compared every cycle, plus directed literal checks.
module tb_rom_prog_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int WORDS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        erase_en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic [31:0] rd_addr_i = '0;
    logic [31:0] rd_data_o;
    logic        busy_o, cpu_hold_o, overflow_o;
    logic [AW:0] wr_count_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rom_prog_ctrl #(
        .ADDR_W       (AW),
        .FIFO_DEPTH   (DEPTH),
        .HOLD_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .erase_en_i (erase_en_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .busy_o     (busy_o),
        .cpu_hold_o (cpu_hold_o),
        .overflow_o (overflow_o),
        .wr_count_o (wr_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory array, write buffer as queues, erase as a position counter.
    logic [31:0] m_mem [WORDS];
    bit          m_known [WORDS];
    int          q_idx [$];
    logic [31:0] q_dat [$];
    bit          m_erasing = 0;
    int          m_sweep = 0;
    bit          m_ovf = 0;
    int          m_cnt = 0;
    bit          m_hold = 0;
    int          m_idle = 0;
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 1;

    task automatic model_step();
        int  ri;
        int  wi;
        bit  in_rng;
        bit  quiet_before;
        ri = int'(rd_addr_i[AW+1:2]);
        wi = int'(wr_addr_i[AW+1:2]);
        in_rng = ((wr_addr_i >> (AW + 2)) == 32'd0);
        quiet_before = !m_erasing && (q_idx.size() == 0);

        m_rd = m_mem[ri];
        m_rd_known = m_known[ri];

        if (m_erasing) begin
            m_mem[m_sweep] = '0;
            m_known[m_sweep] = 1;
        end else if (q_idx.size() > 0 && !erase_en_i) begin
            m_mem[q_idx[0]] = q_dat[0];
            m_known[q_idx[0]] = 1;
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
            if (m_cnt < WORDS) m_cnt++;
        end

        if (erase_en_i) begin
            m_erasing = 1;
            m_sweep = 0;
            q_idx.delete();
            q_dat.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else if (m_erasing) begin
            if (m_sweep == WORDS - 1) m_erasing = 0;
            else m_sweep++;
        end

        if (wr_en_i && in_rng) begin
            if (q_idx.size() < DEPTH) begin
                q_idx.push_back(wi);
                q_dat.push_back(wr_data_i);
            end else begin
                m_ovf = 1;
            end
        end

        if (erase_en_i) m_hold = 1;
        else if (quiet_before && m_idle >= TMO) m_hold = 0;
        m_idle = (erase_en_i || wr_en_i) ? 0 : m_idle + 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_idx.delete();
            q_dat.delete();
            m_erasing = 0;
            m_sweep = 0;
            m_ovf = 0;
            m_cnt = 0;
            m_hold = 0;
            m_idle = 0;
            m_rd = '0;
            m_rd_known = 1;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy", {31'd0, busy_o}, {31'd0, m_erasing});
            chk("cyc_hold", {31'd0, cpu_hold_o}, {31'd0, m_hold});
            chk("cyc_ovf", {31'd0, overflow_o}, {31'd0, m_ovf});
            chk("cyc_count", 32'(wr_count_o), 32'(m_cnt));
            if (m_rd_known) chk("cyc_rd_data", rd_data_o, m_rd);
        end
    end

    int busy_run = 0;
    int busy_len = 0;
    always @(negedge clk) begin
        if (busy_o) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en_i = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic erase();
        erase_en_i = 1'b1;
        tick();
        erase_en_i = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_addr_i = a;
        tick();
        chk(nm, rd_data_o, exp);
    endtask

    task automatic wait_sweep();
        for (int i = 0; i < 100 && busy_o; i++) tick();
        chk("sweep_done", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rd_addr_i = 32'h0C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", rd_data_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        chk("rst_count", 32'(wr_count_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write index 3, keep fetching it: new data appears 3 edges after the strobe.
        wr(32'h0C, 32'hDEADBEEF);
        tick();
        tick();
        chk("t1_read_idx3", rd_data_o, 32'hDEADBEEF);

        // Preload, erase, two writes buffered during the sweep.
        for (int i = 0; i < WORDS; i++) wr(32'(i * 4), 32'hFFFFFFFF);
        repeat (3) tick();
        erase();
        chk("t2_busy_rise", {31'd0, busy_o}, 32'd1);
        chk("t2_hold_rise", {31'd0, cpu_hold_o}, 32'd1);
        tick();
        wr(32'h00, 32'h11111111);
        wr(32'h04, 32'h22222222);
        wait_sweep();
        repeat (3) tick();
        chk("t2_busy_len", 32'(busy_len), 32'd16);
        chk("t2_count", 32'(wr_count_o), 32'd2);
        for (int i = 0; i < WORDS; i++)
            rd_chk(32'(i * 4), (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 : 32'd0, "t2_word");

        // Five writes into a four-entry buffer during the sweep.
        erase();
        for (int k = 0; k < 5; k++) wr(32'(k * 4), 32'hC0DE0000 + 32'(k));
        chk("t3_ovf_set", {31'd0, overflow_o}, 32'd1);
        wait_sweep();
        repeat (6) tick();
        chk("t3_count", 32'(wr_count_o), 32'd4);
        for (int k = 0; k < 4; k++) rd_chk(32'(k * 4), 32'hC0DE0000 + 32'(k), "t3_word");
        rd_chk(32'h10, 32'd0, "t3_dropped_word");
        erase();
        chk("t3_ovf_clr", {31'd0, overflow_o}, 32'd0);
        chk("t3_count_clr", 32'(wr_count_o), 32'd0);

        // Two stale entries, then erase and write together.
        wr(32'h20, 32'h00000001);
        wr(32'h24, 32'h00000002);
        erase_en_i = 1'b1;
        wr_en_i = 1'b1;
        wr_addr_i = 32'h08;
        wr_data_i = 32'hA5A5A5A5;
        tick();
        erase_en_i = 1'b0;
        wr_en_i = 1'b0;
        wait_sweep();
        repeat (4) tick();
        chk("t4_count", 32'(wr_count_o), 32'd1);
        rd_chk(32'h08, 32'hA5A5A5A5, "t4_word2");
        rd_chk(32'h20, 32'd0, "t4_stale8");
        rd_chk(32'h24, 32'd0, "t4_stale9");

        // Hold persists across spaced writes and drops 21 edges after the last strobe.
        erase();
        wait_sweep();
        wr(32'h04, 32'h5A5A0001);
        repeat (9) tick();
        wr(32'h14, 32'h5A5A0005);
        repeat (9) tick();
        chk("t5_hold_mid", {31'd0, cpu_hold_o}, 32'd1);
        wr(32'h18, 32'h5A5A0006);
        repeat (20) tick();
        chk("t5_hold_before", {31'd0, cpu_hold_o}, 32'd1);
        tick();
        chk("t5_hold_fall", {31'd0, cpu_hold_o}, 32'd0);

        // Out-of-range write and wrapped fetch.
        wr(32'h40, 32'hBAD0BAD0);
        repeat (3) tick();
        chk("t6_count_same", 32'(wr_count_o), 32'd3);
        rd_chk(32'h00, 32'd0, "t6_word0_untouched");
        rd_chk(32'h44, 32'h5A5A0001, "t6_wrap_read");

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
